// File: rtl/multimode_ring_counter_pkg.sv
// Shared constants and helpers for the multimode ring counter.
//   MODE_RING / MODE_JOHNSON : values of the mode input and of mode_q
//   DIR_LEFT  / DIR_RIGHT    : values of the dir input
//   seed(mode)               : start state of a mode, 32 bits wide; callers size-cast it
package multimode_ring_counter_pkg;

    localparam logic MODE_RING    = 1'b0;
    localparam logic MODE_JOHNSON = 1'b1;
    localparam logic DIR_LEFT     = 1'b0;
    localparam logic DIR_RIGHT    = 1'b1;

    // Ring starts with bit 0 set and Johnson starts from all-zeros.
    function automatic logic [31:0] seed(input logic mode);
        return (mode == MODE_JOHNSON) ? 32'd0 : 32'd1;
    endfunction

endpackage

// File: rtl/ring_state_decode.sv
// Purely combinational state decoder for the multimode ring counter.
// Ports:
//   q      in  WIDTH  current counter state
//   mode_q in  1      active mode (MODE_RING / MODE_JOHNSON)
//   legal  out 1      q is a member of the active mode's sequence
//   pos    out PW     index of q in the left-shift sequence, 0 when illegal
module ring_state_decode
    import multimode_ring_counter_pkg::*;
#(
    parameter int WIDTH = 4,
    localparam int PW = $clog2(2 * WIDTH)
) (
    input  logic [WIDTH-1:0] q,
    input  logic             mode_q,
    output logic             legal,
    output logic [PW-1:0]    pos
);

    logic [PW:0]      ones;
    logic [PW-1:0]    ring_idx;
    logic [WIDTH-1:0] inv_q;
    logic             low_anchored;
    logic             high_anchored;

    always_comb begin
        ones     = '0;
        ring_idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            ones = ones + (PW + 1)'(q[i]);
            if (q[i]) ring_idx = PW'(i);
        end
    end

    // q = 0..01..1 exactly when q + 1 shares no set bit with q; the
    // high-anchored form 1..10..0 is the same test on ~q.
    assign inv_q         = ~q;
    assign low_anchored  = ((q & (q + WIDTH'(1))) == '0);
    assign high_anchored = ((inv_q & (inv_q + WIDTH'(1))) == '0);

    always_comb begin
        legal = 1'b0;
        pos   = '0;
        if (mode_q == MODE_RING) begin
            legal = (ones == (PW + 1)'(1));
            if (legal) pos = ring_idx;
        end else begin
            legal = low_anchored | high_anchored;
            if (legal) begin
                // Filling phase counts up with the ones; draining phase
                // (ones anchored at the MSB) counts on from W toward 2W-1.
                if (q[0] || (q == '0)) pos = PW'(ones);
                else                   pos = PW'(2 * WIDTH) - PW'(ones);
            end
        end
    end

endmodule

// File: rtl/multimode_ring_counter.sv
// WIDTH-bit one-hot ring / Johnson counter, mode selectable at run time,
// bidirectional, with enable and parallel load.
// Optional feature macro: MULTIMODE_RING_COUNTER_SELFCORRECT_EN
//   defined   : an illegal state is replaced by the active mode's seed on the next edge
//   undefined : illegal states shift like legal ones and persist
// Ports:
//   clk      in  1      rising-edge clock
//   reset    in  1      asynchronous active-high reset
//   en       in  1      advance one state per clock
//   load     in  1      load load_val (highest priority)
//   load_val in  WIDTH  value to load, not checked for legality
//   mode     in  1      0 = ring, 1 = Johnson
//   dir      in  1      0 = toward MSB, 1 = toward LSB
//   q        out WIDTH  registered counter state
//   pos      out PW     state index from q and the registered mode
//   tc       out 1      next shift returns to the seed
//   err      out 1      registered illegal-state flag
module multimode_ring_counter
    import multimode_ring_counter_pkg::*;
#(
    parameter int WIDTH = 4,
    localparam int PW = $clog2(2 * WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             mode,
    input  logic             dir,
    output logic [WIDTH-1:0] q,
    output logic [PW-1:0]    pos,
    output logic             tc,
    output logic             err
);

    logic             mode_q;
    logic             legal;
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] seed_cur;
    logic [WIDTH-1:0] seed_new;

    assign seed_cur = WIDTH'(seed(mode_q));
    assign seed_new = WIDTH'(seed(mode));

    ring_state_decode #(.WIDTH(WIDTH)) u_decode (
        .q      (q),
        .mode_q (mode_q),
        .legal  (legal),
        .pos    (pos)
    );

    // Shift follows the registered mode; Johnson feeds back the inverted
    // bit that falls off the end.
    always_comb begin
        shifted = q;
        case ({mode_q, dir})
            {MODE_RING,    DIR_LEFT}:  shifted = {q[WIDTH-2:0], q[WIDTH-1]};
            {MODE_RING,    DIR_RIGHT}: shifted = {q[0], q[WIDTH-1:1]};
            {MODE_JOHNSON, DIR_LEFT}:  shifted = {q[WIDTH-2:0], ~q[WIDTH-1]};
            default:                   shifted = {~q[0], q[WIDTH-1:1]};
        endcase
    end

    always_comb begin
        q_next = q;
        if (load) begin
            q_next = load_val;
        end else if (mode != mode_q) begin
            q_next = seed_new;
        end
`ifdef MULTIMODE_RING_COUNTER_SELFCORRECT_EN
        else if (!legal) begin
            q_next = seed_cur;
        end
`endif
        else if (en) begin
            q_next = shifted;
        end
    end

    assign tc = en & ~load & legal & (shifted == seed_cur);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q      <= WIDTH'(1);
            mode_q <= MODE_RING;
            err    <= 1'b0;
        end else begin
            q      <= q_next;
            mode_q <= mode;
            err    <= ~legal;
        end
    end

endmodule

// File: tb/tb_multimode_ring_counter.sv
// Self-checking bench for multimode_ring_counter: directed walk through the
// ring/Johnson sequences, load and mode-change cases, asynchronous reset,
// then randomized stimulus against an index-based reference model.
module tb_multimode_ring_counter;
    import multimode_ring_counter_pkg::*;

    localparam int W  = 4;
    localparam int PW = $clog2(2 * W);

    logic          clk = 1'b0;
    logic          reset;
    logic          en;
    logic          load;
    logic [W-1:0]  load_val;
    logic          mode;
    logic          dir;
    logic [W-1:0]  q;
    logic [PW-1:0] pos;
    logic          tc;
    logic          err;

    multimode_ring_counter #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .load     (load),
        .load_val (load_val),
        .mode     (mode),
        .dir      (dir),
        .q        (q),
        .pos      (pos),
        .tc       (tc),
        .err      (err)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard / counters ----------------
    int           n_cmp = 0;
    int           n_bad = 0;
    logic [W-1:0] exp_q[$];

    // reference model state
    logic [W-1:0] m_q;
    logic         m_mode;
    logic         m_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int period(input logic md);
        return md ? 2 * W : W;
    endfunction

    // k-th state of the left-shift sequence of a mode.
    function automatic logic [W-1:0] pattern(input logic md, input int k);
        logic [W-1:0] v;
        v = '0;
        for (int i = 0; i < W; i++) begin
            if (!md) v[i] = (i == k);
            else     v[i] = (k <= W) ? (i < k) : (i >= k - W);
        end
        return v;
    endfunction

    // Index of v in the mode's sequence, -1 when it is not a member.
    function automatic int lookup(input logic md, input logic [W-1:0] v);
        int idx;
        idx = -1;
        for (int k = 0; k < period(md); k++)
            if (pattern(md, k) == v) idx = k;
        return idx;
    endfunction

    // Bit-level shift used only for states outside the sequence.
    function automatic logic [W-1:0] raw_shift(input logic md, input logic d, input logic [W-1:0] v);
        int x, msk, r;
        x   = int'(v);
        msk = (1 << W) - 1;
        if (!md && !d)     r = ((x << 1) | (x >> (W - 1))) & msk;
        else if (!md)      r = (x >> 1) | ((x & 1) << (W - 1));
        else if (!d)       r = ((x << 1) & msk) | (((x >> (W - 1)) & 1) ^ 1);
        else               r = (x >> 1) | (((x & 1) ^ 1) << (W - 1));
        return W'(r);
    endfunction

    function automatic int next_idx(input int k, input logic md, input logic d);
        return d ? (k + period(md) - 1) % period(md) : (k + 1) % period(md);
    endfunction

    function automatic logic [W-1:0] model_next(input logic e, input logic l,
                                                input logic [W-1:0] lv, input logic md, input logic d);
        int k;
        k = lookup(m_mode, m_q);
        if (l)                return lv;
        if (md != m_mode)     return pattern(md, 0);
        if (k < 0) begin
`ifdef MULTIMODE_RING_COUNTER_SELFCORRECT_EN
            return pattern(m_mode, 0);
`else
            return e ? raw_shift(m_mode, d, m_q) : m_q;
`endif
        end
        if (!e)               return m_q;
        return pattern(m_mode, next_idx(k, m_mode, d));
    endfunction

    task automatic model_reset();
        m_q    = W'(1);
        m_mode = MODE_RING;
        m_err  = 1'b0;
        exp_q.delete();
    endtask

    // ---------------- driver ----------------
    // Called just after a rising edge: drives inputs, checks combinational
    // outputs on the falling edge, then checks registered outputs after the
    // next rising edge.
    task automatic step(input logic e, input logic l, input logic [W-1:0] lv,
                        input logic md, input logic d);
        int   k;
        logic exp_tc;
        logic nerr;
        en = e; load = l; load_val = lv; mode = md; dir = d;
        @(negedge clk);
        k      = lookup(m_mode, m_q);
        exp_tc = e && !l && (k >= 0) && (next_idx(k, m_mode, d) == 0);
        check("pos", 32'(pos), (k < 0) ? 32'd0 : 32'(k));
        check("tc", 32'(tc), 32'(exp_tc));
        exp_q.push_back(model_next(e, l, lv, md, d));
        nerr = (k < 0);
        @(posedge clk);
        #1;
        m_q    = exp_q.pop_front();
        m_mode = md;
        m_err  = nerr;
        check("q", 32'(q), 32'(m_q));
        check("err", 32'(err), 32'(m_err));
    endtask

    // Asserts reset between edges, checks the immediate effect, releases it
    // and lets one idle edge pass.
    task automatic mid_reset();
        #2 reset = 1'b1;
        en = 1'b0; load = 1'b0; mode = MODE_RING; dir = DIR_LEFT;
        #1;
        check("async_rst_q", 32'(q), 32'd1);
        check("async_rst_err", 32'(err), 32'd0);
        model_reset();
        #2 reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    logic [W-1:0] seq_ring_l[4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [W-1:0] seq_john[8]   = '{4'b0001, 4'b0011, 4'b0111, 4'b1111,
                                    4'b1110, 4'b1100, 4'b1000, 4'b0000};
    logic [W-1:0] seq_ring_r[4] = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};

    initial begin
        logic e, l, md, d;
        reset = 1'b1; en = 1'b0; load = 1'b0; load_val = '0; mode = MODE_RING; dir = DIR_LEFT;
        model_reset();
        #3;
        check("reset_q", 32'(q), 32'd1);
        check("reset_err", 32'(err), 32'd0);
        check("reset_pos", 32'(pos), 32'd0);
        check("reset_tc", 32'(tc), 32'd0);
        #9 reset = 1'b0;
        @(posedge clk);
        #1;

        // ring, left
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, '0, MODE_RING, DIR_LEFT);
            check("ring_left_seq", 32'(q), 32'(seq_ring_l[i]));
        end

        // switch to Johnson, then a full left period
        step(1'b0, 1'b0, '0, MODE_JOHNSON, DIR_LEFT);
        check("john_seed", 32'(q), 32'd0);
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b0, '0, MODE_JOHNSON, DIR_LEFT);
            check("john_left_seq", 32'(q), 32'(seq_john[i]));
        end

        // back to ring, right shift, then hold
        step(1'b0, 1'b0, '0, MODE_RING, DIR_RIGHT);
        check("ring_seed", 32'(q), 32'd1);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, '0, MODE_RING, DIR_RIGHT);
            check("ring_right_seq", 32'(q), 32'(seq_ring_r[i]));
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, '0, MODE_RING, DIR_RIGHT);
            check("hold_q", 32'(q), 32'd1);
        end

        // illegal load in ring mode
        step(1'b0, 1'b1, 4'b0110, MODE_RING, DIR_LEFT);
        check("load_illegal", 32'(q), 32'h6);
        step(1'b1, 1'b0, '0, MODE_RING, DIR_LEFT);
`ifdef MULTIMODE_RING_COUNTER_SELFCORRECT_EN
        check("corrected_q", 32'(q), 32'd1);
`else
        check("rotated_q", 32'(q), 32'hc);
`endif
        check("illegal_err", 32'(err), 32'd1);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, '0, MODE_RING, DIR_LEFT);

        // mode change reseeds; load beats a simultaneous mode change
        step(1'b0, 1'b1, 4'b0100, MODE_RING, DIR_LEFT);
        step(1'b0, 1'b0, '0, MODE_JOHNSON, DIR_LEFT);
        check("mode_change_q", 32'(q), 32'd0);
        step(1'b0, 1'b1, 4'b0100, MODE_RING, DIR_LEFT);
        step(1'b0, 1'b1, 4'b0011, MODE_JOHNSON, DIR_LEFT);
        check("load_vs_mode", 32'(q), 32'h3);
        step(1'b1, 1'b0, '0, MODE_JOHNSON, DIR_LEFT);
        check("john_after_load", 32'(q), 32'h7);
        step(1'b1, 1'b0, '0, MODE_JOHNSON, DIR_LEFT);

        mid_reset();

        // randomized traffic
        md = MODE_RING;
        for (int n = 0; n < 400; n++) begin
            e = ($urandom_range(0, 3) != 0);
            l = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 9) == 0) md = ~md;
            d = 1'($urandom_range(0, 1));
            step(e, l, W'($urandom_range(0, (1 << W) - 1)), md, d);
            if (n % 150 == 149) begin
                mid_reset();
                md = MODE_RING;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
